vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 62 ++++++
 rtl/vga_if.sv | 26 ++
 rtl/vga_axis_counter.sv | 73 +++++++
 rtl/vga_timing_gen.sv | 187 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared timing constants for the 800x600@60 Hz (40 MHz pixel clock) mode.
//   It also holds the output field bundle type and the test-pattern colour
//   table.
//   Timing names: HOR_* describes the horizontal axis and VER_* the vertical
//   axis. *_SYNC_START and *_SYNC_END together give the half-open interval
//   in which the sync pulse is asserted.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int unsigned CNT_W = 11;

  // Horizontal timing (pixel clocks)
  localparam int unsigned HOR_PIXELS      = 800;
  localparam int unsigned HOR_FRONT_PORCH = 40;
  localparam int unsigned HOR_SYNC_LEN    = 128;
  localparam int unsigned HOR_BACK_PORCH  = 88;
  localparam int unsigned HOR_TOTAL       = HOR_PIXELS + HOR_FRONT_PORCH
                                          + HOR_SYNC_LEN + HOR_BACK_PORCH;
  localparam int unsigned HOR_SYNC_START  = HOR_PIXELS + HOR_FRONT_PORCH;
  localparam int unsigned HOR_SYNC_END    = HOR_SYNC_START + HOR_SYNC_LEN;
  localparam logic        HOR_SYNC_POL    = 1'b1;

  // Vertical timing (lines)
  localparam int unsigned VER_PIXELS      = 600;
  localparam int unsigned VER_FRONT_PORCH = 1;
  localparam int unsigned VER_SYNC_LEN    = 4;
  localparam int unsigned VER_BACK_PORCH  = 23;
  localparam int unsigned VER_TOTAL       = VER_PIXELS + VER_FRONT_PORCH
                                          + VER_SYNC_LEN + VER_BACK_PORCH;
  localparam int unsigned VER_SYNC_START  = VER_PIXELS + VER_FRONT_PORCH;
  localparam int unsigned VER_SYNC_END    = VER_SYNC_START + VER_SYNC_LEN;
  localparam logic        VER_SYNC_POL    = 1'b1;

  // Test pattern: eight equal-width vertical colour bars, left to right
  localparam int unsigned NUM_BARS = 8;

  typedef logic [11:0] rgb_t;

  localparam rgb_t BAR_COLOURS [0:NUM_BARS-1] = '{
    12'hFFF,  // white
    12'hFF0,  // yellow
    12'h0FF,  // cyan
    12'h0F0,  // green
    12'hF0F,  // magenta
    12'hF00,  // red
    12'h00F,  // blue
    12'h000   // black
  };

  // Timing fields that travel together through the output register
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
  } timing_t;

endpackage : vga_pkg

// File: rtl/vga_if.sv
// -----------------------------------------------------------------------------
// vga_if
//   Pixel-stream bundle that is passed along the draw chain. The source drives
//   the bundle through the 'out' modport, and each stage in the chain reads it
//   through the 'in' modport.
//   Fields: hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
// -----------------------------------------------------------------------------
interface vga_if;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport in (
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

endinterface : vga_if

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   Generic wrap-around counter for one display axis. The counter holds its
//   value while 'en' is low. When 'en' is high it counts 0..TOTAL-1 and then
//   returns to 0.
//   It also decodes the *next* counter value, so that a downstream register
//   stage can present every field of the same pixel in the same cycle.
//
//   Parameters: TOTAL, ACTIVE, SYNC_START, SYNC_END
//     The sync window is the half-open interval [SYNC_START, SYNC_END).
//   Ports:
//     clk       in   clock
//     rst       in   asynchronous, active-high reset
//     en        in   advance the counter by one this cycle
//     cnt_nxt   out  counter value after the coming edge
//     wrap      out  counter is at TOTAL-1 and en is high (next value is 0)
//     blnk_nxt  out  cnt_nxt >= ACTIVE
//     sync_nxt  out  cnt_nxt lies in the sync window (active-high; the top
//                    level applies the polarity)
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = HOR_TOTAL,
  parameter int unsigned ACTIVE     = HOR_PIXELS,
  parameter int unsigned SYNC_START = HOR_SYNC_START,
  parameter int unsigned SYNC_END   = HOR_SYNC_END
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             wrap,
  output logic             blnk_nxt,
  output logic             sync_nxt
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ACTIVE = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] CNT_SYNC_S = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] CNT_SYNC_E = CNT_W'(SYNC_END);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every output of this block gets a value before any branch, so
  // that no path leaves a signal unassigned and a latch cannot be inferred.
  always_comb begin
    wrap  = en && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    cnt_nxt  = cnt_d;
    blnk_nxt = (cnt_d >= CNT_ACTIVE);
    sync_nxt = (cnt_d >= CNT_SYNC_S) && (cnt_d < CNT_SYNC_E);
  end

  // NOTE: state is written with non-blocking assignments, so that every flop
  // samples the pre-edge values and the order of the statements does not
  // matter. The flop is cleared asynchronously, so a clock is not needed to
  // reach a known state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : vga_axis_counter

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Source end of the vga_if pixel stream for 800x600@60 Hz (40 MHz).
//   It generates hcount/vcount, hsync/vsync and hblnk/vblnk. It also generates
//   one-cycle line_start and frame_start strobes, which step the game logic
//   and the animation.
//   Every output is one register stage deep and is decoded from the next
//   counter value, so all fields describe the same pixel in the same cycle.
//
//   Optional feature (macro VGA_TEST_PATTERN_EN):
//     defined   - rgb shows 8 vertical colour bars across the active area,
//                 and rgb is 0 in blanking
//     undefined - rgb is tied to 12'h000 and no bar logic is built
//
//   Ports:
//     clk          in   pixel clock, 40 MHz
//     rst          in   asynchronous, active-high reset
//     vga_out      vga_if.out  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
//     frame_start  out  one-cycle pulse while the outputs show (0,0)
//     line_start   out  one-cycle pulse while the outputs show hcount==0
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = HOR_PIXELS,
  parameter int unsigned H_FP      = HOR_FRONT_PORCH,
  parameter int unsigned H_SYNC    = HOR_SYNC_LEN,
  parameter int unsigned H_BP      = HOR_BACK_PORCH,
  parameter int unsigned V_ACTIVE  = VER_PIXELS,
  parameter int unsigned V_FP      = VER_FRONT_PORCH,
  parameter int unsigned V_SYNC    = VER_SYNC_LEN,
  parameter int unsigned V_BP      = VER_BACK_PORCH,
  parameter logic        HSYNC_POL = HOR_SYNC_POL,
  parameter logic        VSYNC_POL = VER_SYNC_POL
) (
  input  logic      clk,
  input  logic      rst,
  vga_if.out        vga_out,
  output logic      frame_start,
  output logic      line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam timing_t TIMING_RST = '{
    hcount: '0,
    vcount: '0,
    hsync:  ~HSYNC_POL,
    vsync:  ~VSYNC_POL,
    hblnk:  1'b0,
    vblnk:  1'b0
  };

  logic [CNT_W-1:0] h_cnt_nxt;
  logic [CNT_W-1:0] v_cnt_nxt;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_blnk_nxt;
  logic             v_blnk_nxt;
  logic             h_sync_nxt;
  logic             v_sync_nxt;

  timing_t timing_q;
  timing_t timing_d;
  logic    line_start_q;
  logic    line_start_d;
  logic    frame_start_q;
  logic    frame_start_d;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (1'b1),
    .cnt_nxt  (h_cnt_nxt),
    .wrap     (h_wrap),
    .blnk_nxt (h_blnk_nxt),
    .sync_nxt (h_sync_nxt)
  );

  // The vertical counter advances only on the horizontal wrap. As a result,
  // vsync and vblnk change together with hcount==0 of the new line.
  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (h_wrap),
    .cnt_nxt  (v_cnt_nxt),
    .wrap     (v_wrap),
    .blnk_nxt (v_blnk_nxt),
    .sync_nxt (v_sync_nxt)
  );

  // h_wrap means the next pixel is hcount==0. v_wrap can only fire together
  // with h_wrap, so it means the next pixel is (0,0).
  always_comb begin
    timing_d        = TIMING_RST;
    timing_d.hcount = h_cnt_nxt;
    timing_d.vcount = v_cnt_nxt;
    timing_d.hblnk  = h_blnk_nxt;
    timing_d.vblnk  = v_blnk_nxt;
    timing_d.hsync  = h_sync_nxt ? HSYNC_POL : ~HSYNC_POL;
    timing_d.vsync  = v_sync_nxt ? VSYNC_POL : ~VSYNC_POL;
    line_start_d    = h_wrap;
    frame_start_d   = v_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timing_q      <= TIMING_RST;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      timing_q      <= timing_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // The bar index follows the horizontal counter through a 3-bit bar counter
  // and a 7-bit sub-counter, so no divider is needed. bar_q/sub_q describe
  // the pixel that the horizontal counter currently holds. The _d values
  // describe h_cnt_nxt, which keeps rgb aligned with the other fields.
  localparam int unsigned BAR_W    = H_ACTIVE / NUM_BARS;
  localparam logic [6:0]  SUB_LAST = 7'(BAR_W - 1);

  logic [2:0] bar_q;
  logic [2:0] bar_d;
  logic [6:0] sub_q;
  logic [6:0] sub_d;
  rgb_t       rgb_q;
  rgb_t       rgb_d;

  always_comb begin
    bar_d = bar_q;
    sub_d = sub_q;
    if (h_wrap) begin
      bar_d = '0;
      sub_d = '0;
    end else if (sub_q == SUB_LAST) begin
      bar_d = bar_q + 3'd1;
      sub_d = '0;
    end else begin
      sub_d = sub_q + 7'd1;
    end
    // In horizontal blanking the bar counter runs on freely. Its value there
    // has no meaning, because rgb is forced to 0 throughout blanking.
    rgb_d = (h_blnk_nxt || v_blnk_nxt) ? rgb_t'(12'h000) : BAR_COLOURS[bar_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_q <= '0;
      sub_q <= '0;
      rgb_q <= '0;
    end else begin
      bar_q <= bar_d;
      sub_q <= sub_d;
      rgb_q <= rgb_d;
    end
  end

  assign vga_out.rgb = rgb_q;
`else
  assign vga_out.rgb = 12'h000;
`endif

  assign vga_out.hcount = timing_q.hcount;
  assign vga_out.vcount = timing_q.vcount;
  assign vga_out.hsync  = timing_q.hsync;
  assign vga_out.vsync  = timing_q.vsync;
  assign vga_out.hblnk  = timing_q.hblnk;
  assign vga_out.vblnk  = timing_q.vblnk;
  assign line_start     = line_start_q;
  assign frame_start    = frame_start_q;

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench with two instances:
//     dut   - full 800x600 timing: reset, one line, mid-line async reset,
//             test-pattern line at vcount=10
//     dut_s - the same RTL with reduced timing (24 clocks x 10 lines), so that
//             whole frames, frame_start spacing and a mid-frame reset fit
//             within a short run
//   Small-instance timing: H 16/2/4/2 -> total 24, hsync [18,22)
//                          V  6/1/2/1 -> total 10, vsync [7,9)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int S_HT = 24;
  localparam int S_VT = 10;
  localparam int S_FRAME = S_HT * S_VT;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_s = 1'b1;
  logic fs, ls, fs_s, ls_s;

  vga_if vo ();
  vga_if vs ();

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk         (clk),
    .rst         (rst),
    .vga_out     (vo),
    .frame_start (fs),
    .line_start  (ls)
  );

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
    .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) dut_s (
    .clk         (clk),
    .rst         (rst_s),
    .vga_out     (vs),
    .frame_start (fs_s),
    .line_start  (ls_s)
  );

  int checks   = 0;
  int failures = 0;
  int sh = 0;
  int sv = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_rgb(input int h, input int v, input int ha, input int va);
`ifdef VGA_TEST_PATTERN_EN
    if (h >= ha || v >= va) return 12'h000;
    return BAR_COLOURS[h / (ha / 8)];
`else
    return 12'h000 | 12'(h & 0) | 12'(v & 0) | 12'(ha & 0) | 12'(va & 0);
`endif
  endfunction

  // Advance the small instance by one clock and compare every field with the
  // bench's own model of the reduced timing.
  task automatic small_cycle();
    step();
    sh = (sh == S_HT - 1) ? 0 : sh + 1;
    if (sh == 0) sv = (sv == S_VT - 1) ? 0 : sv + 1;
    check("s_hcount", 32'(vs.hcount), 32'(sh));
    check("s_vcount", 32'(vs.vcount), 32'(sv));
    check("s_hblnk",  32'(vs.hblnk),  32'(sh >= 16));
    check("s_vblnk",  32'(vs.vblnk),  32'(sv >= 6));
    check("s_hsync",  32'(vs.hsync),  32'(sh >= 18 && sh < 22));
    check("s_vsync",  32'(vs.vsync),  32'(sv >= 7 && sv < 9));
    check("s_line_start",  32'(ls_s), 32'(sh == 0));
    check("s_frame_start", 32'(fs_s), 32'(sh == 0 && sv == 0));
    check("s_rgb", 32'(vs.rgb), 32'(exp_rgb(sh, sv, 16, 6)));
  endtask

  task automatic check_reset_vo(input string tag);
    check({tag, "_hcount"}, 32'(vo.hcount), 32'd0);
    check({tag, "_vcount"}, 32'(vo.vcount), 32'd0);
    check({tag, "_hblnk"},  32'(vo.hblnk),  32'd0);
    check({tag, "_vblnk"},  32'(vo.vblnk),  32'd0);
    check({tag, "_hsync"},  32'(vo.hsync),  32'd0);
    check({tag, "_vsync"},  32'(vo.vsync),  32'd0);
    check({tag, "_rgb"},    32'(vo.rgb),    32'd0);
    check({tag, "_fs"},     32'(fs),        32'd0);
    check({tag, "_ls"},     32'(ls),        32'd0);
  endtask

  task automatic check_reset_vs(input string tag);
    check({tag, "_hcount"}, 32'(vs.hcount), 32'd0);
    check({tag, "_vcount"}, 32'(vs.vcount), 32'd0);
    check({tag, "_hblnk"},  32'(vs.hblnk),  32'd0);
    check({tag, "_vblnk"},  32'(vs.vblnk),  32'd0);
    check({tag, "_hsync"},  32'(vs.hsync),  32'd0);
    check({tag, "_vsync"},  32'(vs.vsync),  32'd0);
    check({tag, "_rgb"},    32'(vs.rgb),    32'd0);
    check({tag, "_fs"},     32'(fs_s),      32'd0);
    check({tag, "_ls"},     32'(ls_s),      32'd0);
  endtask

  initial begin
    int hs_cnt;
    int hs_first;
    int hs_last;
    int ls_cnt;
    int fs_idx [$];

    // ---- Reset: hold for 5 clocks, check reset state, release ----
    rst   = 1'b1;
    rst_s = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_vo("rst");
    rst = 1'b0;
    step();
    check("first_hcount", 32'(vo.hcount), 32'd1);
    check("first_vcount", 32'(vo.vcount), 32'd0);
    check("first_ls",     32'(ls),        32'd0);

    // ---- One line on the full-size instance ----
    repeat (798) step();
    check("h799_hcount", 32'(vo.hcount), 32'd799);
    check("h799_hblnk",  32'(vo.hblnk),  32'd0);
    check("h799_rgb",    32'(vo.rgb),    32'(exp_rgb(799, 0, 800, 600)));
    step();
    check("h800_hblnk",  32'(vo.hblnk),  32'd1);
    check("h800_hsync",  32'(vo.hsync),  32'd0);
    check("h800_rgb",    32'(vo.rgb),    32'd0);

    hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
    for (int i = 801; i <= 1055; i++) begin
      step();
      if (vo.hsync === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(vo.hcount);
        hs_last = int'(vo.hcount);
      end
      if (ls === 1'b1) ls_cnt++;
      if (i == 968) check("h968_hsync", 32'(vo.hsync), 32'd0);
    end
    check("h1055_hcount", 32'(vo.hcount), 32'd1055);
    check("h1055_vcount", 32'(vo.vcount), 32'd0);
    check("hsync_width",  32'(hs_cnt),    32'd128);
    check("hsync_first",  32'(hs_first),  32'd840);
    check("hsync_last",   32'(hs_last),   32'd967);
    check("ls_in_blank",  32'(ls_cnt),    32'd0);
    step();
    check("wrap_hcount", 32'(vo.hcount), 32'd0);
    check("wrap_vcount", 32'(vo.vcount), 32'd1);
    check("wrap_ls",     32'(ls),        32'd1);
    check("wrap_fs",     32'(fs),        32'd0);
    check("wrap_hblnk",  32'(vo.hblnk),  32'd0);
    step();
    check("after_wrap_ls", 32'(ls), 32'd0);

    // ---- Mid-line asynchronous reset at (412,1) ----
    repeat (411) step();
    check("pre_rst_hcount", 32'(vo.hcount), 32'd412);
    check("pre_rst_vcount", 32'(vo.vcount), 32'd1);
    #1 rst = 1'b1;
    #1 check_reset_vo("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("resume_hcount", 32'(vo.hcount), 32'd1);
    check("resume_vcount", 32'(vo.vcount), 32'd0);

    // ---- Line at vcount=10: colour bars (or all zero) ----
    repeat (10559) step();
    check("v10_hcount", 32'(vo.hcount), 32'd0);
    check("v10_vcount", 32'(vo.vcount), 32'd10);
    check("v10_ls",     32'(ls),        32'd1);
    for (int h = 0; h < 1056; h++) begin
      check("v10_rgb", 32'(vo.rgb), 32'(exp_rgb(h, 10, 800, 600)));
      step();
    end
    check("v11_vcount", 32'(vo.vcount), 32'd11);

    // ---- Small instance: three full frames against the model ----
    @(negedge clk);
    check_reset_vs("s_rst");
    rst_s = 1'b0;
    sh = 0; sv = 0;
    for (int n = 1; n <= 3 * S_FRAME; n++) begin
      small_cycle();
      if (fs_s === 1'b1) fs_idx.push_back(n);
    end
    check("s_fs_count", 32'(fs_idx.size()), 32'd3);
    if (fs_idx.size() == 3) begin
      check("s_fs_first",  32'(fs_idx[0]),             32'(S_FRAME));
      check("s_fs_period", 32'(fs_idx[1] - fs_idx[0]), 32'(S_FRAME));
      check("s_fs_period", 32'(fs_idx[2] - fs_idx[1]), 32'(S_FRAME));
    end

    // ---- Small instance: mid-frame asynchronous reset at (10,4) ----
    repeat (4 * S_HT + 10) small_cycle();
    check("s_pre_rst_hcount", 32'(vs.hcount), 32'd10);
    check("s_pre_rst_vcount", 32'(vs.vcount), 32'd4);
    #1 rst_s = 1'b1;
    #1 check_reset_vs("s_async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_s = 1'b0;
    sh = 0; sv = 0;
    fs_idx.delete();
    for (int n = 1; n <= S_FRAME + 5; n++) begin
      small_cycle();
      if (fs_s === 1'b1) fs_idx.push_back(n);
    end
    check("s_rst_fs_count", 32'(fs_idx.size()), 32'd1);
    if (fs_idx.size() >= 1) check("s_rst_fs_first", 32'(fs_idx[0]), 32'(S_FRAME));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vga_timing_gen
